// File: rtl/decode_queue_if.sv
// Fetch, redirect and dispatch signals of the decode queue.
// slave is the queue side, master the fetch/execute/dispatch side.
interface decode_queue_if #(
   parameter int IW = 16
);
   logic [IW-1:0] I1, I2, I1PC, I2PC;
   logic          I1V, I2V, I1P, I2P;
   logic          stall;
   logic          R0w;
   logic [IW-1:0] R0d;
   logic          redirect_valid;
   logic [IW-1:0] redirect_pc;
   logic          dispatch_stall;
   logic [IW-1:0] D1, D2, D1PC, D2PC;
   logic          D1V, D2V, D1P, D2P;

   modport slave (
      input  I1, I2, I1PC, I2PC, I1V, I2V, I1P, I2P,
      input  redirect_valid, redirect_pc, dispatch_stall,
      output stall, R0w, R0d,
      output D1, D2, D1PC, D2PC, D1V, D2V, D1P, D2P
   );

   modport master (
      output I1, I2, I1PC, I2PC, I1V, I2V, I1P, I2P,
      output redirect_valid, redirect_pc, dispatch_stall,
      input  stall, R0w, R0d,
      input  D1, D2, D1PC, D2PC, D1V, D2V, D1P, D2P
   );
endinterface

// File: rtl/decode_queue.sv
// Two-wide in-order instruction queue between fetch and dispatch,
// with back-pressure and redirect-driven PC override.
module decode_queue #(
   parameter int IW    = 16,
   parameter int DEPTH = 8
) (
   input logic           clk,
   input logic           flush,
   decode_queue_if.slave q
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [IW-1:0]    mem_i  [DEPTH];
   logic [IW-1:0]    mem_pc [DEPTH];
   logic [DEPTH-1:0] mem_p;

   logic [PW-1:0] head, tail, head1, tail1, i2slot;
   logic [CW-1:0] count, n_enq, n_deq;
   logic          d1v, d2v, enq_ok;
   logic          r0w;
   logic [IW-1:0] r0d;

   always_comb begin
      head1  = head + PW'(1);
      tail1  = tail + PW'(1);
      i2slot = q.I1V ? tail1 : tail;
      d1v    = (count != '0);
      d2v    = (count >= CW'(2));
      // stall depends on registered count only
      q.stall = (count > CW'(DEPTH - 2));
      enq_ok  = !q.stall && !q.redirect_valid && !r0w;
      n_enq   = '0;
      if (enq_ok)
         n_enq = CW'(q.I1V) + CW'(q.I2V);
      n_deq = '0;
      if (!q.dispatch_stall)
         n_deq = CW'(d1v) + CW'(d2v);
   end

   always_comb begin
      q.D1V  = d1v;
      q.D2V  = d2v;
      q.D1   = d1v ? mem_i[head]   : '0;
      q.D1PC = d1v ? mem_pc[head]  : '0;
      q.D1P  = d1v ? mem_p[head]   : 1'b0;
      q.D2   = d2v ? mem_i[head1]  : '0;
      q.D2PC = d2v ? mem_pc[head1] : '0;
      q.D2P  = d2v ? mem_p[head1]  : 1'b0;
      q.R0w  = r0w;
      q.R0d  = r0d;
   end

   always_ff @(posedge clk) begin
      if (!flush && enq_ok) begin
         if (q.I1V) begin
            mem_i[tail]  <= q.I1;
            mem_pc[tail] <= q.I1PC;
            mem_p[tail]  <= q.I1P;
         end
         if (q.I2V) begin
            mem_i[i2slot]  <= q.I2;
            mem_pc[i2slot] <= q.I2PC;
            mem_p[i2slot]  <= q.I2P;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (flush) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
         r0w   <= 1'b0;
         r0d   <= '0;
      end else if (q.redirect_valid) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
         r0w   <= 1'b1;
         r0d   <= q.redirect_pc;
      end else begin
         head  <= head + PW'(n_deq);
         tail  <= tail + PW'(n_enq);
         count <= count + n_enq - n_deq;
         r0w   <= 1'b0;
      end
   end
endmodule

// File: tb/tb_decode_queue.sv
// Directed bench for decode_queue: reset, streaming, fill,
// compaction, redirect, flush priority and pointer wrap.
module tb_decode_queue;
   localparam int IW = 16;

   logic clk = 1'b0;
   logic flush;
   int   npass = 0;
   int   ntot  = 0;

   decode_queue_if #(.IW(IW)) vif ();

   decode_queue #(.IW(IW), .DEPTH(8)) dut (
      .clk   (clk),
      .flush (flush),
      .q     (vif.slave)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      ntot++;
      assert (obs === exp) npass++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   task automatic bundle(input logic v1, input logic [15:0] a,
                         input logic [15:0] apc, input logic ap,
                         input logic v2, input logic [15:0] b,
                         input logic [15:0] bpc, input logic bp);
      vif.I1V = v1; vif.I1 = a; vif.I1PC = apc; vif.I1P = ap;
      vif.I2V = v2; vif.I2 = b; vif.I2PC = bpc; vif.I2P = bp;
   endtask

   initial begin
      logic [15:0] sq [$];
      int sent;
      bit st;
      flush = 1'b1;
      vif.redirect_valid = 1'b0;
      vif.redirect_pc = '0;
      vif.dispatch_stall = 1'b0;
      bundle(1, 16'hAAAA, 16'h0, 0, 1, 16'hBBBB, 16'h1, 0);

      // reset held with valid bundle
      for (int i = 0; i < 4; i++) begin
         step();
         chk("rst_d1v", 32'(vif.D1V), 32'd0);
         chk("rst_d2v", 32'(vif.D2V), 32'd0);
         chk("rst_stall", 32'(vif.stall), 32'd0);
         chk("rst_r0w", 32'(vif.R0w), 32'd0);
         chk("rst_r0d", 32'(vif.R0d), 32'd0);
      end

      // streaming
      flush = 1'b0;
      bundle(1, 16'h1111, 16'h0, 0, 1, 16'h2222, 16'h1, 1);
      step();
      chk("str1_d1", 32'(vif.D1), 32'h1111);
      chk("str1_d2", 32'(vif.D2), 32'h2222);
      chk("str1_pc2", 32'(vif.D2PC), 32'h1);
      chk("str1_p2", 32'(vif.D2P), 32'd1);
      chk("str1_v", 32'({vif.D1V, vif.D2V}), 32'd3);
      bundle(1, 16'h3333, 16'h2, 0, 1, 16'h4444, 16'h3, 0);
      step();
      chk("str2_d1", 32'(vif.D1), 32'h3333);
      chk("str2_d2", 32'(vif.D2), 32'h4444);
      chk("str2_stall", 32'(vif.stall), 32'd0);
      bundle(0, 0, 0, 0, 0, 0, 0, 0);
      step();
      chk("str3_d1v", 32'(vif.D1V), 32'd0);

      // fill with dispatch stalled
      vif.dispatch_stall = 1'b1;
      for (int i = 0; i < 4; i++) begin
         bundle(1, 16'(16'h10 + 2 * i), 16'(16'h10 + 2 * i), 0,
                1, 16'(16'h11 + 2 * i), 16'(16'h11 + 2 * i), 1);
         step();
         chk("fill_stall", 32'(vif.stall), (i == 3) ? 32'd1 : 32'd0);
      end
      bundle(1, 16'hDEAD, 16'h0, 0, 1, 16'hDEAD, 16'h0, 0);
      step();
      chk("fill_hold", 32'(vif.stall), 32'd1);
      chk("fill_d1", 32'(vif.D1), 32'h10);
      chk("fill_d2p", 32'(vif.D2P), 32'd1);
      bundle(0, 0, 0, 0, 0, 0, 0, 0);
      vif.dispatch_stall = 1'b0;
      step();
      chk("drain1_d1", 32'(vif.D1), 32'h12);
      chk("drain1_stall", 32'(vif.stall), 32'd0);
      step();
      chk("drain2_d1", 32'(vif.D1), 32'h14);
      step();
      chk("drain3_d1", 32'(vif.D1), 32'h16);
      chk("drain3_d2", 32'(vif.D2), 32'h17);
      step();
      chk("drain4_d1v", 32'(vif.D1V), 32'd0);

      // single-slot compaction
      vif.dispatch_stall = 1'b1;
      bundle(0, 16'h5555, 16'h5, 0, 1, 16'hBEEF, 16'h40, 1);
      step();
      chk("cmp_d1", 32'(vif.D1), 32'hBEEF);
      chk("cmp_d1p", 32'(vif.D1P), 32'd1);
      chk("cmp_d1pc", 32'(vif.D1PC), 32'h40);
      chk("cmp_v", 32'({vif.D1V, vif.D2V}), 32'd2);
      chk("cmp_d2", 32'(vif.D2), 32'd0);

      // redirect with five entries held
      bundle(1, 16'h21, 16'h41, 0, 1, 16'h22, 16'h42, 0);
      step();
      bundle(1, 16'h23, 16'h43, 0, 1, 16'h24, 16'h44, 0);
      step();
      chk("rd_pre_d1", 32'(vif.D1), 32'hBEEF);
      chk("rd_pre_d2", 32'(vif.D2), 32'h21);
      bundle(1, 16'h25, 16'h45, 0, 1, 16'h26, 16'h46, 0);
      vif.dispatch_stall = 1'b0;
      vif.redirect_valid = 1'b1;
      vif.redirect_pc = 16'h00C8;
      step();
      chk("rd_d1v", 32'(vif.D1V), 32'd0);
      chk("rd_r0w", 32'(vif.R0w), 32'd1);
      chk("rd_r0d", 32'(vif.R0d), 32'h00C8);
      chk("rd_stall", 32'(vif.stall), 32'd0);
      vif.redirect_valid = 1'b0;
      bundle(1, 16'h77, 16'h50, 0, 1, 16'h78, 16'h51, 0);
      step();
      chk("rd_r0w_off", 32'(vif.R0w), 32'd0);
      chk("rd_drop", 32'(vif.D1V), 32'd0);
      bundle(1, 16'h79, 16'hC8, 1, 1, 16'h7A, 16'hC9, 0);
      step();
      chk("rd_next_d1", 32'(vif.D1), 32'h79);
      chk("rd_next_d2", 32'(vif.D2), 32'h7A);
      chk("rd_next_pc", 32'(vif.D1PC), 32'hC8);

      // back-to-back redirects
      bundle(0, 0, 0, 0, 0, 0, 0, 0);
      vif.redirect_valid = 1'b1;
      vif.redirect_pc = 16'h0100;
      step();
      chk("b2b1_r0d", 32'(vif.R0d), 32'h0100);
      vif.redirect_pc = 16'h0200;
      step();
      chk("b2b2_r0w", 32'(vif.R0w), 32'd1);
      chk("b2b2_r0d", 32'(vif.R0d), 32'h0200);
      vif.redirect_valid = 1'b0;
      step();
      chk("b2b3_r0w", 32'(vif.R0w), 32'd0);

      // flush beats redirect
      flush = 1'b1;
      vif.redirect_valid = 1'b1;
      vif.redirect_pc = 16'h0333;
      step();
      chk("fr_r0w", 32'(vif.R0w), 32'd0);
      chk("fr_r0d", 32'(vif.R0d), 32'd0);
      chk("fr_d1v", 32'(vif.D1V), 32'd0);
      flush = 1'b0;
      vif.redirect_valid = 1'b0;

      // 20 double bundles across pointer wrap
      sent = 0;
      for (int cyc = 0; cyc < 300; cyc++) begin
         if (sent == 20 && sq.size() == 0) break;
         vif.dispatch_stall = (cyc % 2 == 1);
         bundle(sent < 20, 16'(16'h300 + 2 * sent), 16'(2 * sent), 0,
                sent < 20, 16'(16'h301 + 2 * sent), 16'(2 * sent + 1), 1);
         chk("wrap_d1v", 32'(vif.D1V), 32'(sq.size() >= 1));
         if (sq.size() >= 1) chk("wrap_d1", 32'(vif.D1), 32'(sq[0]));
         if (sq.size() >= 2) chk("wrap_d2", 32'(vif.D2), 32'(sq[1]));
         st = (sq.size() > 6);
         chk("wrap_stall", 32'(vif.stall), 32'(st));
         if (!vif.dispatch_stall)
            for (int k = 0; k < 2; k++)
               if (sq.size() > 0) void'(sq.pop_front());
         if (!st && sent < 20) begin
            sq.push_back(16'(16'h300 + 2 * sent));
            sq.push_back(16'(16'h301 + 2 * sent));
            sent++;
         end
         step();
      end
      chk("wrap_done", 32'(sent == 20 && sq.size() == 0), 32'd1);
      chk("wrap_empty", 32'(vif.D1V), 32'd0);

      $display("%0d/%0d checks passed", npass, ntot);
      $finish;
   end
endmodule

// File: doc/decode_queue.md
Name: decode_queue

Overview:
- Consumer end of the two-wide fetch interface: accepts the I1/I2 bundle (instruction, valid, predict bit, PC) from the fetch stage and buffers it in an in-order circular queue.
- Presents up to two oldest entries per cycle to decode/dispatch.
- Generates the `stall` back-pressure that fetch consumes.
- Drives the fetch PC-override pair (R0w/R0d) when a redirect arrives from execute, discarding all buffered and in-flight wrong-path instructions.

Parameters:
- IW, 16, instruction and PC width in bits
- DEPTH, 8, queue entries; power of two, >= 4

Ports:
- clk  in  1  clock, all state updates on rising edge
- flush  in  1  synchronous active-high reset; also pipeline flush
- I1  in  IW  fetched instruction slot 1 (older)
- I2  in  IW  fetched instruction slot 2 (younger)
- I1V  in  1  slot 1 valid
- I2V  in  1  slot 2 valid
- I1P  in  1  slot 1 predict bit, carried through unchanged
- I2P  in  1  slot 2 predict bit, carried through unchanged
- I1PC  in  IW  slot 1 PC
- I2PC  in  IW  slot 2 PC
- stall  out  1  to fetch: hold current bundle, do not advance
- R0w  out  1  to fetch: load R0 (PC) with R0d this edge
- R0d  out  IW  to fetch: redirect target PC
- redirect_valid  in  1  execute requests refetch from redirect_pc
- redirect_pc  in  IW  redirect target
- dispatch_stall  in  1  downstream cannot accept this cycle
- D1, D2  out  IW  oldest and second-oldest instruction
- D1V, D2V  out  1  entry valid
- D1P, D2P  out  1  predict bits
- D1PC, D2PC  out  IW  PCs

Behaviour:
- Storage: DEPTH entries of {instr, pc, pred}; head/tail pointers wrap modulo DEPTH; count is clog2(DEPTH)+1 bits, range 0..DEPTH.
- Reset (flush=1 at edge): head=tail=count=0, R0w=0, R0d=0. Consequently D1V=D2V=0 and stall=0. flush overrides every other input.
- stall = (count > DEPTH-2). Combinational from registered count only; no path from any input to stall.
- Enqueue occurs at the edge when stall=0, redirect_valid=0 and R0w=0.
  - Valid slots are compacted in order: I1 (if I1V) at tail, then I2 (if I2V) at the next slot.
  - I1V=0 with I2V=1: I2 takes the tail slot.
  - Enqueue count is 0, 1 or 2.
  - When stall=1, the bundle is ignored; fetch re-presents it.
- Dequeue outputs:
  - D1* = entry[head] and D2* = entry[head+1], read combinationally from registered storage.
  - D1V = (count>=1); D2V = (count>=2).
  - Invalid slots drive 0 on their data, PC and predict outputs.
- Dequeue occurs at the edge when dispatch_stall=0, removing D1V+D2V entries. The pair is consumed together; no partial acceptance.
- Simultaneous enqueue and dequeue in one edge: count_next = count + enq - deq. Entries freed that cycle are not reused for that cycle's enqueue, since stall uses the pre-edge count.
- Redirect (redirect_valid=1 at edge, flush=0):
  - head=tail=count=0; dequeue and enqueue suppressed.
  - Next cycle: R0w=1 and R0d=redirect_pc, for exactly one cycle.
  - While R0w=1, the fetch bundle is discarded as wrong-path.
  - Back-to-back redirects: the later target wins. R0w stays 1 and R0d updates each cycle.
- Latency: an instruction enqueued at edge N is visible on D1/D2 after edge N; minimum fetch-to-dispatch latency is one cycle.
- Ordering is strict program order; the predict bit and PC travel with their instruction.

Test Plan:
- Reset: flush=1 for 4 cycles with I1V=I2V=1 -> D1V=D2V=0, stall=0, R0w=0, R0d=0 throughout; first bundle after deassert appears one cycle later.
- Streaming: I1/I2=0x1111/0x2222 (PC 0/1), then 0x3333/0x4444 (PC 2/3), dispatch_stall=0 -> D1/D2 show 0x1111/0x2222, then 0x3333/0x4444; count never exceeds 2; stall never asserts.
- Fill: dispatch_stall=1, four double bundles with DEPTH=8 -> stall asserts once count=7 or 8, here exactly after the 4th bundle (count=8). Extra bundles are ignored. Releasing dispatch_stall drains in order; stall drops when count<=6.
- Single-slot compaction: I1V=0, I2V=1 with I2=0xBEEF and I2P=1 -> D1=0xBEEF, D1P=1, D1V=1, D2V=0.
- Redirect: queue holding 5 entries, redirect_valid=1 with redirect_pc=0x00C8 -> next cycle count=0, D1V=0, R0w=1, R0d=0x00C8 for one cycle; bundle during R0w=1 dropped; the following bundle is enqueued.
- Wrap and simultaneous events: run 20 double bundles with alternating dispatch_stall -> output order matches input order across pointer wrap. flush and redirect_valid asserted together -> reset wins, R0w stays 0.
